// File: rtl/nand_fn_sweep_pkg.sv
// Shared types and constants for the NAND/NOT function-block sweep sequencer.
package nand_fn_sweep_pkg;

    // Sequencer phases: wait for start, let the datapath settle, sample w, report.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int VEC_W   = 4;   // {a,b,c,d}
    localparam int NUM_VEC = 16;  // exhaustive input space
    localparam int CNT_W   = 5;   // mismatch count 0..16

    // Truth table of w = ~((c|d) & ((a&b)|~d)); bit i is w for {a,b,c,d} = i.
    localparam logic [NUM_VEC-1:0] GOLDEN_W = 16'h1BBB;

endpackage

// File: rtl/nand_fn_sweep_ctrl_settle_timer.sv
// Loadable 4-bit down-counter that times how long each vector is held.
module sweep_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic       zero_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Load has priority; the count never goes below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/nand_fn_sweep_ctrl.sv
// Sweep sequencer: drives all 16 {a,b,c,d} vectors into the function block,
// waits SETTLE_CYCLES per vector, checks w against EXPECTED and reports the
// pass flag, mismatch count and first failing vector.
// SETTLE_CYCLES must lie in 1..15 and cover the datapath's worst-case delay.
module nand_fn_sweep_ctrl
    import nand_fn_sweep_pkg::*;
#(
    parameter int                 SETTLE_CYCLES = 4,
    parameter logic [NUM_VEC-1:0] EXPECTED      = GOLDEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_w,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             aborted,
    output logic [CNT_W-1:0] err_count,
    output logic             fail_valid,
    output logic [VEC_W-1:0] first_fail_idx,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SETTLE = SETTLE;
    localparam logic [1:0] S_SAMPLE = SAMPLE;
    localparam logic [1:0] S_DONE   = DONE;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_IDX    = 4'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] ERR_MAX     = 5'(NUM_VEC);

    logic [1:0]       state_q, state_d;
    logic [VEC_W-1:0] idx_q, idx_d;
    logic [VEC_W-1:0] abcd_q, abcd_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             fv_q, fv_d;
    logic [VEC_W-1:0] ffi_q, ffi_d;
    logic             pass_q, pass_d;
    logic             abrt_q, abrt_d;
    logic             done_q, done_d;

    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_zero;

    sweep_settle_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (SETTLE_LOAD),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    // Next-state and result bookkeeping for the sweep.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        abcd_d   = abcd_q;
        err_d    = err_q;
        fv_d     = fv_q;
        ffi_d    = ffi_q;
        pass_d   = pass_q;
        abrt_d   = abrt_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // start beats a simultaneous abort: abort is not looked at here.
                if (start) begin
                    idx_d    = '0;
                    abcd_d   = '0;
                    err_d    = '0;
                    fv_d     = 1'b0;
                    ffi_d    = '0;
                    pass_d   = 1'b0;
                    abrt_d   = 1'b0;
                    tmr_load = 1'b1;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    abrt_d  = 1'b1;
                    state_d = S_DONE;
                end else if (tmr_zero) begin
                    state_d = S_SAMPLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    // The vector being sampled is dropped, not compared.
                    abrt_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    // Case inequality so an X/Z on w is reported as a failure.
                    if (dut_w !== EXPECTED[idx_q]) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 5'd1;
                        end
                        if (!fv_q) begin
                            fv_d  = 1'b1;
                            ffi_d = idx_q;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        abcd_d   = idx_q + 4'd1;
                        tmr_load = 1'b1;
                        state_d  = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                // err_q already includes the last SAMPLE's result here.
                done_d  = 1'b1;
                pass_d  = (err_q == '0) && !abrt_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            abcd_q  <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ffi_q   <= '0;
            pass_q  <= 1'b0;
            abrt_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            abcd_q  <= abcd_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ffi_q   <= ffi_d;
            pass_q  <= pass_d;
            abrt_q  <= abrt_d;
            done_q  <= done_d;
        end
    end

    assign {a, b, c, d}   = abcd_q;
    assign busy           = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done           = done_q;
    assign pass           = pass_q;
    assign aborted        = abrt_q;
    assign err_count      = err_q;
    assign fail_valid     = fv_q;
    assign first_fail_idx = ffi_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_nand_fn_sweep_ctrl.sv
// Directed bench for nand_fn_sweep_ctrl: behavioural datapath models
// (ideal, stuck-at-0, stuck-at-1, slow 27 ns) feed the sequencer.
module tb_nand_fn_sweep_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start, abort, start1;
    int   w_mode;

    logic       a, b, c, d, busy, done, pass, aborted, fail_valid;
    logic [4:0] err_count;
    logic [3:0] first_fail_idx;
    logic [1:0] state_dbg;
    logic       dut_w;

    logic       a1, b1, c1, d1, busy1, done1, pass1, aborted1, fail_valid1;
    logic [4:0] err_count1;
    logic [3:0] first_fail_idx1;
    logic [1:0] state_dbg1;
    logic       w_slow1;

    logic w_ideal, w_slow0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic fn_w(input logic [3:0] v);
        return ~((v[1] | v[0]) & ((v[3] & v[2]) | ~v[0]));
    endfunction

    assign w_ideal    = fn_w({a, b, c, d});
    assign #27 w_slow0 = fn_w({a, b, c, d});
    assign #27 w_slow1 = fn_w({a1, b1, c1, d1});
    assign dut_w = (w_mode == 0) ? w_ideal :
                   (w_mode == 1) ? 1'b0 :
                   (w_mode == 2) ? 1'b1 : w_slow0;

    nand_fn_sweep_ctrl #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_w(dut_w),
        .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .pass(pass),
        .aborted(aborted), .err_count(err_count), .fail_valid(fail_valid),
        .first_fail_idx(first_fail_idx), .state_dbg(state_dbg)
    );

    nand_fn_sweep_ctrl #(.SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .dut_w(w_slow1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
        .aborted(aborted1), .err_count(err_count1), .fail_valid(fail_valid1),
        .first_fail_idx(first_fail_idx1), .state_dbg(state_dbg1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a sweep on the main instance and counts edges until done.
    // poke_idx >= 0 re-pulses start when that vector is on a..d;
    // abort_idx >= 0 raises abort for one cycle in that vector's SETTLE.
    task automatic run_sweep(input int poke_idx, input int abort_idx,
                             input bit abort_with_start, output int cycles);
        logic [3:0] prev;
        bit poked = 0;
        bit abrt_done = 0;
        cycles = 0;
        @(negedge clk);
        start = 1'b1;
        abort = abort_with_start;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("accept_busy", busy, 1'b1);
        prev = {a, b, c, d};
        check("first_vector", prev, 4'd0);
        while (cycles < 2000) begin
            @(posedge clk);
            cycles++;
            #1;
            start = 1'b0;
            abort = 1'b0;
            if ({a, b, c, d} != prev) begin
                check("vector_step", {a, b, c, d}, 4'(prev + 4'd1));
                prev = {a, b, c, d};
            end
            if (done) break;
            if (poke_idx >= 0 && !poked && {a, b, c, d} == 4'(poke_idx)) begin
                start = 1'b1;
                poked = 1;
            end
            if (abort_idx >= 0 && !abrt_done && {a, b, c, d} == 4'(abort_idx)) begin
                check("abort_in_settle", state_dbg, 2'd1);
                abort = 1'b1;
                abrt_done = 1;
            end
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_abcd"}, {a, b, c, d}, 4'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_pass"}, pass, 1'b0);
        check({tag, "_aborted"}, aborted, 1'b0);
        check({tag, "_err"}, err_count, 5'd0);
        check({tag, "_fv"}, fail_valid, 1'b0);
        check({tag, "_ffi"}, first_fail_idx, 4'd0);
        check({tag, "_state"}, state_dbg, 2'd0);
    endtask

    initial begin
        int cyc;
        int n;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        start1 = 1'b0;
        w_mode = 0;
        #1;
        check_reset_outputs("reset");
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // 1: golden datapath, full sweep
        run_sweep(-1, -1, 0, cyc);
        check("golden_latency", cyc, 81);
        check("golden_pass", pass, 1'b1);
        check("golden_err", err_count, 5'd0);
        check("golden_fv", fail_valid, 1'b0);
        check("golden_aborted", aborted, 1'b0);
        check("golden_last_vec", {a, b, c, d}, 4'd15);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 1'b0);
        check("abcd_hold_idle", {a, b, c, d}, 4'd15);
        check("pass_held", pass, 1'b1);

        // 2: stuck-at-0 then stuck-at-1
        w_mode = 1;
        run_sweep(-1, -1, 0, cyc);
        check("sa0_err", err_count, 5'd10);
        check("sa0_ffi", first_fail_idx, 4'd0);
        check("sa0_fv", fail_valid, 1'b1);
        check("sa0_pass", pass, 1'b0);
        w_mode = 2;
        run_sweep(-1, -1, 0, cyc);
        check("sa1_err", err_count, 5'd6);
        check("sa1_ffi", first_fail_idx, 4'd2);
        check("sa1_pass", pass, 1'b0);

        // 3: slow datapath (27 ns) with 10 ns clock, SETTLE 1 vs 4
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("slow_s1_done", done1, 1'b1);
        check("slow_s1_fv", fail_valid1, 1'b1);
        check("slow_s1_ffi", first_fail_idx1, 4'd2);
        check("slow_s1_pass", pass1, 1'b0);
        w_mode = 3;
        run_sweep(-1, -1, 0, cyc);
        check("slow_s4_pass", pass, 1'b1);
        check("slow_s4_err", err_count, 5'd0);

        // 4: reset during vector 7
        w_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ({a, b, c, d} != 4'd7 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reached_vec7", {a, b, c, d}, 4'd7);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_sweep(-1, -1, 0, cyc);
        check("post_rst_latency", cyc, 81);
        check("post_rst_pass", pass, 1'b1);

        // 5: abort in vector 5 SETTLE with stuck-at-0 (vectors 0..4 give 4 errors)
        w_mode = 1;
        run_sweep(-1, 5, 0, cyc);
        check("abort_latency", cyc, 27);
        check("abort_aborted", aborted, 1'b1);
        check("abort_pass", pass, 1'b0);
        check("abort_err", err_count, 5'd4);
        check("abort_ffi", first_fail_idx, 4'd0);
        check("abort_vec_hold", {a, b, c, d}, 4'd5);

        // abort alongside start in IDLE: start wins, aborted clears
        w_mode = 0;
        run_sweep(-1, -1, 1, cyc);
        check("start_abort_latency", cyc, 81);
        check("start_abort_aborted", aborted, 1'b0);
        check("start_abort_pass", pass, 1'b1);

        // 6: extra start at vector 3 is ignored
        run_sweep(3, -1, 0, cyc);
        check("restart_ignored_latency", cyc, 81);
        check("restart_ignored_pass", pass, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_poke", state_dbg, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nand_fn_sweep_ctrl.md
Name: nand_fn_sweep_ctrl

Overview:
Sequencer that exhaustively exercises the 4-input NAND/NOT switch-level function block w = ~((c|d) & ((a&b)|~d)).
- Drives all 16 input combinations {a,b,c,d} in order.
- Waits a programmable settle time for transistor propagation delays.
- Samples w, compares it against a golden truth table, and reports a pass flag, mismatch count and first failing vector.
- Sits between a testbench or top-level start control and the gate-level datapath.

Parameters:
- SETTLE_CYCLES, 4, clock cycles the vector is held before sampling; legal range 1..15.
- EXPECTED, 16'h1BBB, golden truth table; bit i is the expected w for vector i = {a,b,c,d}, with a as MSB.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level sampled in IDLE; begins a sweep.
- abort  in  1  synchronous; ends a sweep early.
- dut_w  in  1  output w of the datapath under control.
- a, b, c, d  out  1 each  registered datapath inputs.
- busy  out  1  high in SETTLE and SAMPLE.
- done  out  1  one-cycle pulse at end of sweep, including an aborted sweep.
- pass  out  1  valid from done until the next start; 1 iff err_count==0 and no abort.
- aborted  out  1  set by abort; cleared on start.
- err_count  out  5  mismatch count, range 0..16.
- fail_valid  out  1  at least one mismatch seen this sweep.
- first_fail_idx  out  4  index of the first mismatching vector; meaningful only when fail_valid=1.

Behaviour:
Reset values (asynchronous):
- state=IDLE, idx=0, {a,b,c,d}=0.
- busy=0, done=0, pass=0, aborted=0, err_count=0, fail_valid=0, first_fail_idx=0.
- rst asserted mid-sweep returns all of the above to their reset values immediately; no done pulse is generated.

States:
- IDLE: if start=1, clear idx, err_count, fail_valid, first_fail_idx, pass and aborted; drive {a,b,c,d}=0; load settle counter with SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: decrement the counter each cycle; when the counter is 0, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - Compare dut_w with EXPECTED[idx]. Use case inequality, so X or Z counts as a mismatch.
  - On mismatch: err_count++. If fail_valid=0, set first_fail_idx=idx and fail_valid=1.
  - If idx==15: go to DONE.
  - Otherwise: idx++, drive {a,b,c,d}=idx+1, reload the counter, go to SETTLE.
- DONE (1 cycle): done=1; pass=(err_count==0)&~aborted, using the updated count; go to IDLE.

Timing and control rules:
- Full sweep latency: done asserts 16*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge.
- start is ignored outside IDLE.
- If start is still high in the cycle after DONE, a new sweep begins immediately.
- abort in SETTLE or SAMPLE: set aborted=1 and go to DONE. A comparison in that same SAMPLE cycle is not performed. abort in IDLE or DONE has no effect.
- abort and start together in IDLE: start wins; abort is ignored.
- {a,b,c,d} hold their last value in IDLE.
- err_count never wraps; 16 is the maximum and fits in 5 bits.
- Integration constraint: SETTLE_CYCLES*Tclk must exceed the worst datapath delay (3 gate levels at 9 ns fall delay each); the integrator checks this. With a 10 ns clock, SETTLE_CYCLES ≥ 3.

Decomposition:
- Package nand_fn_sweep_pkg holds:
  - enum state_t {IDLE, SETTLE, SAMPLE, DONE};
  - localparam VEC_W=4, NUM_VEC=16, CNT_W=5;
  - GOLDEN_W=16'h1BBB, used as the default for EXPECTED.
- One sub-module, sweep_settle_timer: a loadable 4-bit down-counter with load, enable and zero outputs.

Test Plan:
1. Golden behavioural DUT, SETTLE_CYCLES=4, pulse start → done at cycle 81 after accept; pass=1, err_count=0, fail_valid=0; a..d step 0→15.
2. dut_w stuck-at-0 → err_count=10, first_fail_idx=0, pass=0. Stuck-at-1 → err_count=6, first_fail_idx=2.
3. Actual switch-level nand_/not_ netlist, 10 ns clock, SETTLE_CYCLES=1 → mismatches appear (fail_valid=1). Rerun with SETTLE_CYCLES=4 → pass=1.
4. Assert rst during vector 7 → all outputs return to reset values within the same timestep; no done pulse; a new start runs a clean full sweep with pass=1.
5. Assert abort in vector 5 SETTLE → done next cycle, aborted=1, pass=0, err_count reflects only vectors 0..4.
6. Pulse start again at vector 3 → ignored; done timing unchanged at cycle 81.
